coax_line_ctrl: RTL and testbench
=================================

// Module: coax_line_ctrl
// PURPOSE
//  Half-duplex transaction sequencer for the coax line. On a host start it pulses the
//  transmitter and waits for it to finish. After a turnaround gap it enables the receiver
//  and waits for a response frame within a timeout. It then drains received 10-bit words
//  to the host with a strobe and ends with a done pulse and a result code.
// PARAMETERS
//  CLOCKS_PER_BIT    8     clocks per coax bit; sets the turnaround and timeout scale
//  TURNAROUND_BITS   2     bit times with rx disabled after tx_active falls
//  RESPONSE_TIMEOUT  4800  clocks allowed from rx enable to rx_active rising
//  MAX_WORDS         1023  words forwarded per transaction; the excess is dropped (<=1023)
// PORTS
//  clk               in   1   system clock
//  reset             in   1   asynchronous, active-high reset
//  start             in   1   begin transaction; ignored while busy=1
//  expect_response   in   1   sampled with start; 0 = transmit-only transaction
//  busy              out  1   high from the cycle after an accepted start through DONE
//  tx_start          out  1   one-clock pulse to the transmitter
//  tx_active         in   1   transmitter busy
//  rx_enable         out  1   receiver enable (low = receiver held in idle)
//  rx_active         in   1   receiver is inside a frame
//  rx_data           in   10  received word
//  rx_data_available in   1   receiver word valid
//  rx_data_read      out  1   one-clock acknowledge of rx_data
//  word              out  10  forwarded word
//  word_strobe       out  1   one-clock pulse: word valid
//  word_count        out  10  words forwarded this transaction; cleared on accepted start
//  done              out  1   one-clock pulse at transaction end
//  result            out  2   0 OK, 1 TIMEOUT, 2 OVERFLOW, 3 ABORTED; held until next start
// BEHAVIOUR
//  - Reset (async): state=IDLE; all outputs 0, including word, word_count and result.
//    Reset asserted mid-transaction stops it immediately, with no done pulse.
//  - All outputs are registered.
//  - IDLE: start=1 -> TX_START; latch expect_response; clear word_count and result.
//  - TX_START (1 clk): tx_start=1 -> TX_ARM.
//  - TX_ARM (1 clk): tx_active is ignored -> TX_WAIT.
//  - TX_WAIT: tx_active=0 -> TURNAROUND if expect_response, else DONE with result=OK.
//  - TURNAROUND: rx_enable=0 for TURNAROUND_BITS*CLOCKS_PER_BIT clocks -> RX_WAIT.
//  - RX_WAIT: rx_enable=1; a timer counts from entry.
//    - rx_active=1 -> RX_RECEIVE.
//    - Timer reaches RESPONSE_TIMEOUT without rx_active -> DONE, result=TIMEOUT.
//    - rx_active rising on the expiry clock wins: go to RX_RECEIVE.
//  - RX_RECEIVE: rx_enable=1.
//    - Capture when rx_data_available=1 and rx_data_read=0: next clk word<=rx_data,
//      word_strobe=1 and rx_data_read=1, all for exactly one clk.
//    - The rx_data_read=0 guard prevents double capture while available clears.
//    - Each capture increments word_count while word_count<MAX_WORDS.
//    - At MAX_WORDS the word is still acked but not forwarded (no strobe); result:=OVERFLOW.
//    - Frame end: rx_active=0, rx_data_available=0 and rx_data_read=0 -> DONE.
//      A word pending at the fall of rx_active is drained first.
//  - DONE (1 clk): done=1; rx_enable=0; result is final -> IDLE. busy=0 from IDLE.
//  - rx_data_available outside RX_RECEIVE is ignored and never acked.
// CONFIGURATION
//  - COAX_LINE_CTRL_ABORT_EN defined: adds input `abort` (1 bit).
//    - abort=1 in any state except IDLE/DONE -> DONE next clk with result=ABORTED.
//    - tx_start and rx_data_read are forced 0 that clk.
//    - abort beats all other transitions on the same clk.
//  - COAX_LINE_CTRL_ABORT_EN undefined: no abort port; result value 3 is never produced.
// TESTING
//  1. Transmit-only transaction:
//     start with expect_response=0; tx_active high 20 clks.
//     -> one tx_start pulse; done once after tx_active falls; result=0; rx_enable never 1.
//  2. Normal response:
//     expect_response=1; receiver returns 3 words 0x2A5,0x001,0x3FF.
//     -> 3 word_strobe pulses with those values; word_count=3; done; result=0.
//  3. Response timeout:
//     expect_response=1, rx_active never rises.
//     -> done exactly RESPONSE_TIMEOUT clks after rx_enable rises; result=1; word_count=0.
//  4. Overflow with MAX_WORDS=2:
//     receive 4 words.
//     -> 2 strobes; 4 rx_data_read pulses; word_count=2; result=2.
//  5. Tail drain and start-while-busy:
//     rx_active falls on the same clk rx_data_available rises; start pulsed mid-rx.
//     -> last word still strobed before done; the extra start is ignored.
//  6. Mid-transaction events:
//     - reset asserted during RX_RECEIVE -> outputs 0 immediately, no done.
//     - with ABORT_EN, abort during TX_WAIT -> done next clk, result=3.

Source files
------------

// File: rtl/coax_line_ctrl.sv
// -----------------------------------------------------------------------------
// coax_line_ctrl
//
// Half-duplex transaction sequencer for the coax line. A host start pulses the
// transmitter and waits for it to go idle. If a response is expected, the
// receiver is held disabled for a turnaround gap. It is then enabled, and the
// block waits for a frame within a timeout. Received 10-bit words are drained
// to the host with a strobe. Every transaction ends with a one-clock done pulse
// and a result code.
//
// Optional feature:
//   COAX_LINE_CTRL_ABORT_EN  adds the `abort` input, which ends any active
//                            transaction on the next clock with result ABORTED.
//
// Parameters:
//   CLOCKS_PER_BIT    clocks per coax bit
//   TURNAROUND_BITS   bit times the receiver stays disabled after tx_active falls
//   RESPONSE_TIMEOUT  clocks allowed from rx_enable rising to rx_active rising
//   MAX_WORDS         words forwarded per transaction (<= 1023); extras are
//                     acknowledged but dropped
//
// Ports:
//   clk               in   system clock
//   reset             in   asynchronous, active-high reset
//   start             in   begin transaction (ignored while busy)
//   expect_response   in   sampled with start; 0 = transmit-only
//   abort             in   (COAX_LINE_CTRL_ABORT_EN only) end transaction now
//   busy              out  transaction in progress (through DONE)
//   tx_start          out  one-clock pulse to the transmitter
//   tx_active         in   transmitter busy
//   rx_enable         out  receiver enable
//   rx_active         in   receiver is inside a frame
//   rx_data           in   received word
//   rx_data_available in   received word valid
//   rx_data_read      out  one-clock acknowledge of rx_data
//   word              out  forwarded word
//   word_strobe       out  one-clock pulse, word valid
//   word_count        out  words forwarded in this transaction
//   done              out  one-clock pulse at transaction end
//   result            out  0 OK, 1 TIMEOUT, 2 OVERFLOW, 3 ABORTED
// -----------------------------------------------------------------------------
module coax_line_ctrl #(
   parameter int CLOCKS_PER_BIT   = 8,
   parameter int TURNAROUND_BITS  = 2,
   parameter int RESPONSE_TIMEOUT = 4800,
   parameter int MAX_WORDS        = 1023
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       expect_response,
`ifdef COAX_LINE_CTRL_ABORT_EN
   input  logic       abort,
`endif
   output logic       busy,
   output logic       tx_start,
   input  logic       tx_active,
   output logic       rx_enable,
   input  logic       rx_active,
   input  logic [9:0] rx_data,
   input  logic       rx_data_available,
   output logic       rx_data_read,
   output logic [9:0] word,
   output logic       word_strobe,
   output logic [9:0] word_count,
   output logic       done,
   output logic [1:0] result
);

   // One shared timer covers both the turnaround gap and the response window.
   localparam int TA_CLKS   = TURNAROUND_BITS * CLOCKS_PER_BIT;
   localparam int TIMER_MAX = (RESPONSE_TIMEOUT > TA_CLKS) ? RESPONSE_TIMEOUT : TA_CLKS;
   localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

   localparam logic [TIMER_W-1:0] TA_LAST    = TIMER_W'(TA_CLKS - 1);
   localparam logic [TIMER_W-1:0] TO_LAST    = TIMER_W'(RESPONSE_TIMEOUT - 1);
   localparam logic [9:0]         WORD_LIMIT = 10'(MAX_WORDS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TX_START,
      ST_TX_ARM,
      ST_TX_WAIT,
      ST_TURNAROUND,
      ST_RX_WAIT,
      ST_RX_RECEIVE,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      RES_OK       = 2'd0,
      RES_TIMEOUT  = 2'd1,
      RES_OVERFLOW = 2'd2,
      RES_ABORTED  = 2'd3
   } result_t;

   state_t               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q;
   logic                 expect_q;
   logic                 busy_q;
   logic                 tx_start_q;
   logic                 rx_enable_q;
   logic                 rx_data_read_q;
   logic [9:0]           word_q;
   logic                 word_strobe_q;
   logic [9:0]           word_count_q;
   logic                 done_q;
   result_t              result_q;

   logic                 abort_hit;
   logic                 accept;
   logic                 capture;
   logic                 forward;
   logic                 timeout_hit;

   // An abort only matters while a transaction is actually running.
`ifdef COAX_LINE_CTRL_ABORT_EN
   assign abort_hit = abort && (state_q != ST_IDLE) && (state_q != ST_DONE);
`else
   assign abort_hit = 1'b0;
`endif

   always_comb begin
      accept      = (state_q == ST_IDLE) && start;
      // The rx_data_read_q guard stops a second capture of the same word while
      // the receiver is still dropping rx_data_available.
      capture     = (state_q == ST_RX_RECEIVE) && rx_data_available &&
                    !rx_data_read_q && !abort_hit;
      forward     = capture && (word_count_q < WORD_LIMIT);
      // rx_active on the expiry clock takes priority over the timeout.
      timeout_hit = (state_q == ST_RX_WAIT) && !rx_active && (timer_q == TO_LAST);

      // NOTE: state_d gets a default before the case so that every path assigns
      // it; a missing default in always_comb is how latches get inferred.
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:       if (start) state_d = ST_TX_START;
         ST_TX_START:   state_d = ST_TX_ARM;
         // tx_active may not have risen yet, so it is ignored for one clock.
         ST_TX_ARM:     state_d = ST_TX_WAIT;
         ST_TX_WAIT:    if (!tx_active) state_d = expect_q ? ST_TURNAROUND : ST_DONE;
         ST_TURNAROUND: if (timer_q == TA_LAST) state_d = ST_RX_WAIT;
         ST_RX_WAIT: begin
            if (rx_active)        state_d = ST_RX_RECEIVE;
            else if (timeout_hit) state_d = ST_DONE;
         end
         // The frame ends only after any word pending at the rx_active fall has
         // been acknowledged and the acknowledge has completed.
         ST_RX_RECEIVE: if (!rx_active && !rx_data_available && !rx_data_read_q)
                           state_d = ST_DONE;
         ST_DONE:       state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase

      if (abort_hit) state_d = ST_DONE;
   end

   // All outputs are registered from the state being entered, so each one is
   // valid for exactly the clocks spent in the corresponding state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         timer_q        <= '0;
         expect_q       <= 1'b0;
         busy_q         <= 1'b0;
         tx_start_q     <= 1'b0;
         rx_enable_q    <= 1'b0;
         rx_data_read_q <= 1'b0;
         word_q         <= '0;
         word_strobe_q  <= 1'b0;
         word_count_q   <= '0;
         done_q         <= 1'b0;
         result_q       <= RES_OK;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values; later assignments in this block override earlier.
         state_q        <= state_d;
         busy_q         <= (state_d != ST_IDLE);
         tx_start_q     <= (state_d == ST_TX_START);
         rx_enable_q    <= (state_d == ST_RX_WAIT) || (state_d == ST_RX_RECEIVE);
         done_q         <= (state_d == ST_DONE);
         rx_data_read_q <= capture;
         word_strobe_q  <= forward;

         if (state_d != state_q)
            timer_q <= '0;
         else if ((state_q == ST_TURNAROUND) || (state_q == ST_RX_WAIT))
            timer_q <= timer_q + TIMER_W'(1);

         if (accept) begin
            expect_q     <= expect_response;
            word_count_q <= '0;
            result_q     <= RES_OK;
         end

         if (forward) begin
            word_q       <= rx_data;
            word_count_q <= word_count_q + 10'd1;
         end

         // Word acknowledged but dropped: the frame was longer than allowed.
         if (capture && !forward) result_q <= RES_OVERFLOW;
         if (timeout_hit)         result_q <= RES_TIMEOUT;
         if (abort_hit)           result_q <= RES_ABORTED;
      end
   end

   assign busy         = busy_q;
   assign tx_start     = tx_start_q;
   assign rx_enable    = rx_enable_q;
   assign rx_data_read = rx_data_read_q;
   assign word         = word_q;
   assign word_strobe  = word_strobe_q;
   assign word_count   = word_count_q;
   assign done         = done_q;
   assign result       = result_q;

endmodule

// File: tb/tb_coax_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_coax_line_ctrl
//
// Directed bench for coax_line_ctrl. Two instances share all inputs: `dut`
// uses the default parameters and `dut_ovf` uses MAX_WORDS=2 for the overflow
// case. Expected values are hand-derived from the transaction timing.
// -----------------------------------------------------------------------------
module tb_coax_line_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic       expect_response;
   logic       tx_active;
   logic       rx_active;
   logic [9:0] rx_data;
   logic       rx_data_available;
`ifdef COAX_LINE_CTRL_ABORT_EN
   logic       abort;
`endif

   logic       busy, tx_start, rx_enable, rx_data_read, word_strobe, done;
   logic [9:0] word, word_count;
   logic [1:0] result;

   logic       o_busy, o_tx_start, o_rx_enable, o_rx_data_read, o_word_strobe, o_done;
   logic [9:0] o_word, o_word_count;
   logic [1:0] o_result;

   coax_line_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .expect_response   (expect_response),
`ifdef COAX_LINE_CTRL_ABORT_EN
      .abort             (abort),
`endif
      .busy              (busy),
      .tx_start          (tx_start),
      .tx_active         (tx_active),
      .rx_enable         (rx_enable),
      .rx_active         (rx_active),
      .rx_data           (rx_data),
      .rx_data_available (rx_data_available),
      .rx_data_read      (rx_data_read),
      .word              (word),
      .word_strobe       (word_strobe),
      .word_count        (word_count),
      .done              (done),
      .result            (result)
   );

   coax_line_ctrl #(.MAX_WORDS(2)) dut_ovf (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .expect_response   (expect_response),
`ifdef COAX_LINE_CTRL_ABORT_EN
      .abort             (abort),
`endif
      .busy              (o_busy),
      .tx_start          (o_tx_start),
      .tx_active         (tx_active),
      .rx_enable         (o_rx_enable),
      .rx_active         (rx_active),
      .rx_data           (rx_data),
      .rx_data_available (rx_data_available),
      .rx_data_read      (o_rx_data_read),
      .word              (o_word),
      .word_strobe       (o_word_strobe),
      .word_count        (o_word_count),
      .done              (o_done),
      .result            (o_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitors, sampled on the falling edge away from the active edge.
   int         n_txs, n_done, n_rxen, n_stb, n_rd;
   int         o_stb, o_rd, o_ndone;
   logic [9:0] wq[$];
   logic [9:0] owq[$];

   initial begin
      n_txs = 0; n_done = 0; n_rxen = 0; n_stb = 0; n_rd = 0;
      o_stb = 0; o_rd = 0; o_ndone = 0;
   end

   always @(negedge clk) begin
      if (tx_start)     n_txs++;
      if (done)         n_done++;
      if (rx_enable)    n_rxen++;
      if (rx_data_read) n_rd++;
      if (word_strobe) begin
         n_stb++;
         wq.push_back(word);
      end
      if (o_rx_data_read) o_rd++;
      if (o_done)         o_ndone++;
      if (o_word_strobe) begin
         o_stb++;
         owq.push_back(o_word);
      end
   end

   int n_cmp;
   int n_err;
   int b_txs, b_done, b_rxen, b_stb, b_rd, b_ostb, b_ord, b_odone;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_txs  = n_txs;  b_done = n_done; b_rxen = n_rxen; b_stb  = n_stb;
      b_rd   = n_rd;   b_ostb = o_stb;  b_ord  = o_rd;   b_odone = o_ndone;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_txn(input logic exp);
      start           = 1'b1;
      expect_response = exp;
      tick();
      start     = 1'b0;
      tx_active = 1'b1;
   endtask

   task automatic finish_tx(input int hold);
      repeat (hold) tick();
      tx_active = 1'b0;
   endtask

   task automatic wait_rx_enable(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (rx_enable !== 1'b1 && n < 100);
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (done !== 1'b1 && n < limit);
   endtask

   // Receiver side of the handshake: present a word until it is acknowledged.
   task automatic send_word(input logic [9:0] v);
      int n;
      rx_data           = v;
      rx_data_available = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (rx_data_read !== 1'b1 && n < 10);
      check("rx_ack_seen", rx_data_read, 1);
      rx_data_available = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      n_cmp = 0;
      n_err = 0;

      reset             = 1'b1;
      start             = 1'b0;
      expect_response   = 1'b0;
      tx_active         = 1'b0;
      rx_active         = 1'b0;
      rx_data           = '0;
      rx_data_available = 1'b0;
`ifdef COAX_LINE_CTRL_ABORT_EN
      abort             = 1'b0;
`endif

      // ---- reset state --------------------------------------------------
      repeat (3) tick();
      check("rst_busy",        busy, 0);
      check("rst_tx_start",    tx_start, 0);
      check("rst_rx_enable",   rx_enable, 0);
      check("rst_rx_read",     rx_data_read, 0);
      check("rst_word",        word, 0);
      check("rst_strobe",      word_strobe, 0);
      check("rst_word_count",  word_count, 0);
      check("rst_done",        done, 0);
      check("rst_result",      result, 0);
      check("rst_ovf_outputs", {o_busy, o_tx_start, o_rx_enable, o_rx_data_read, o_word,
                                o_word_strobe, o_word_count, o_done, o_result}, 0);
      reset = 1'b0;
      tick();
      check("idle_busy", busy, 0);

      // ---- 1: transmit-only ----------------------------------------------
      snap();
      start_txn(1'b0);
      check("t1_tx_start", tx_start, 1);
      check("t1_busy",     busy, 1);
      finish_tx(20);
      tick();
      check("t1_done",      done, 1);
      check("t1_result",    result, 0);
      tick();
      check("t1_idle_busy", busy, 0);
      check("t1_n_tx_start", n_txs - b_txs, 1);
      check("t1_n_done",     n_done - b_done, 1);
      check("t1_n_rx_en",    n_rxen - b_rxen, 0);

      // ---- 2: normal response --------------------------------------------
      snap();
      start_txn(1'b1);
      finish_tx(5);
      wait_rx_enable(n);
      check("t2_turnaround_clks", n, 17);
      rx_active = 1'b1;
      tick();
      send_word(10'h2A5);
      send_word(10'h001);
      send_word(10'h3FF);
      rx_active = 1'b0;
      wait_done(20, n);
      check("t2_done",       done, 1);
      check("t2_word_count", word_count, 3);
      check("t2_result",     result, 0);
      tick();
      check("t2_idle_busy",  busy, 0);
      check("t2_n_strobe",   n_stb - b_stb, 3);
      check("t2_n_done",     n_done - b_done, 1);
      if (wq.size() >= b_stb + 3) begin
         check("t2_word0", wq[b_stb],     10'h2A5);
         check("t2_word1", wq[b_stb + 1], 10'h001);
         check("t2_word2", wq[b_stb + 2], 10'h3FF);
      end

      // ---- 3: response timeout -------------------------------------------
      snap();
      start_txn(1'b1);
      finish_tx(3);
      wait_rx_enable(n);
      check("t3_rx_enable", rx_enable, 1);
      wait_done(5000, n);
      check("t3_timeout_clks", n, 4800);
      check("t3_result",       result, 1);
      check("t3_word_count",   word_count, 0);
      check("t3_rx_en_low",    rx_enable, 0);
      tick();
      check("t3_n_done",   n_done - b_done, 1);
      check("t3_n_strobe", n_stb - b_stb, 0);

      // ---- 4: overflow on the MAX_WORDS=2 instance -----------------------
      snap();
      start_txn(1'b1);
      finish_tx(3);
      wait_rx_enable(n);
      rx_active = 1'b1;
      tick();
      send_word(10'h011);
      send_word(10'h022);
      send_word(10'h033);
      send_word(10'h044);
      rx_active = 1'b0;
      wait_done(20, n);
      check("t4_ovf_done",       o_done, 1);
      check("t4_ovf_word_count", o_word_count, 2);
      check("t4_ovf_result",     o_result, 2);
      check("t4_ovf_word_held",  o_word, 10'h022);
      tick();
      check("t4_ovf_n_strobe", o_stb - b_ostb, 2);
      check("t4_ovf_n_read",   o_rd - b_ord, 4);
      check("t4_ovf_n_done",   o_ndone - b_odone, 1);
      if (owq.size() >= b_ostb + 2) begin
         check("t4_ovf_word0", owq[b_ostb],     10'h011);
         check("t4_ovf_word1", owq[b_ostb + 1], 10'h022);
      end
      check("t4_main_result", result, 0);

      // ---- 5: tail drain and start while busy ----------------------------
      snap();
      start_txn(1'b1);
      finish_tx(3);
      wait_rx_enable(n);
      rx_active = 1'b1;
      tick();
      send_word(10'h155);
      start = 1'b1;
      tick();
      start = 1'b0;
      send_word(10'h0AA);
      // rx_active falls on the same clock a new word appears.
      rx_data           = 10'h3C3;
      rx_data_available = 1'b1;
      rx_active         = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (rx_data_read !== 1'b1 && n < 10);
      check("t5_tail_strobe",  word_strobe, 1);
      check("t5_tail_word",    word, 10'h3C3);
      check("t5_tail_no_done", done, 0);
      rx_data_available = 1'b0;
      wait_done(10, n);
      check("t5_done",       done, 1);
      check("t5_word_count", word_count, 3);
      check("t5_result",     result, 0);
      tick();
      check("t5_idle_busy",  busy, 0);
      tick();
      check("t5_no_restart", busy, 0);
      check("t5_n_tx_start", n_txs - b_txs, 1);
      check("t5_n_strobe",   n_stb - b_stb, 3);
      check("t5_n_done",     n_done - b_done, 1);

      // ---- 6a: reset during RX_RECEIVE -----------------------------------
      snap();
      start_txn(1'b1);
      finish_tx(3);
      wait_rx_enable(n);
      rx_active = 1'b1;
      tick();
      send_word(10'h2F0);
      check("t6_pre_count", word_count, 1);
      reset = 1'b1;
      #1;
      check("t6_busy",       busy, 0);
      check("t6_rx_enable",  rx_enable, 0);
      check("t6_word",       word, 0);
      check("t6_word_count", word_count, 0);
      check("t6_result",     result, 0);
      rx_active = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (2) tick();
      check("t6_no_done", n_done - b_done, 0);
      check("t6_idle",    busy, 0);

`ifdef COAX_LINE_CTRL_ABORT_EN
      // ---- 6b: abort during TX_WAIT --------------------------------------
      snap();
      start_txn(1'b1);
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t6b_done",     done, 1);
      check("t6b_result",   result, 3);
      check("t6b_tx_start", tx_start, 0);
      tx_active = 1'b0;
      tick();
      check("t6b_idle",       busy, 0);
      check("t6b_result_hold", result, 3);
      check("t6b_n_done",     n_done - b_done, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
